// File: rtl/serial_full_subtract_if.sv
// serial_full_subtract_if: start/done handshake bus (start, chain, a, b, borrow_in -> diff, borrow_out, overflow, zero, busy, done)
interface serial_full_subtract_if #(parameter int WIDTH = 8);
  logic start;
  logic chain;
  logic borrow_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic borrow_out;
  logic overflow;
  logic zero;
  logic busy;
  logic done;
  modport master(output start, chain, borrow_in, a, b, input diff, borrow_out, overflow, zero, busy, done);
  modport slave(input start, chain, borrow_in, a, b, output diff, borrow_out, overflow, zero, busy, done);
endinterface

// File: rtl/serial_full_subtract.sv
// serial_full_subtract: bit-serial a-b-borrow, one bit per clk LSB first; ports clk, reset, bus (slave: operands in, result/flags/busy/done out)
module serial_full_subtract #(parameter int WIDTH = 8) (
  input logic clk,
  input logic reset,
  serial_full_subtract_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [5:0] LAST = 6'(WIDTH - 1);
  state_t state;
  logic [WIDTH-1:0] sa, sb, res, nd;
  logic [WIDTH:0] nres;
  logic [5:0] cnt;
  logic br, br_next, d, a_msb, b_msb;
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    nres = {d, res};
    nd = nres[WIDTH:1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      res <= '0;
      cnt <= '0;
      br <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      bus.diff <= '0;
      bus.borrow_out <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sa <= bus.a;
          sb <= bus.b;
          br <= bus.chain ? bus.borrow_out : bus.borrow_in;
          cnt <= '0;
          a_msb <= bus.a[WIDTH-1];
          b_msb <= bus.b[WIDTH-1];
          bus.busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          br <= br_next;
          res <= nd;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) begin
            // results are published only here, so an aborted run never leaks a partial diff
            bus.diff <= nd;
            bus.borrow_out <= br_next;
            bus.overflow <= (a_msb != b_msb) & (nd[WIDTH-1] != a_msb);
            bus.zero <= nd == '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_full_subtract.sv
// tb_serial_full_subtract: table-driven scoreboard bench for WIDTH=8 and WIDTH=1 instances
module tb_serial_full_subtract;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst8, rst1;
  serial_full_subtract_if #(.WIDTH(8)) i8();
  serial_full_subtract_if #(.WIDTH(1)) i1();
  serial_full_subtract #(.WIDTH(8)) u8(.clk(clk), .reset(rst8), .bus(i8));
  serial_full_subtract #(.WIDTH(1)) u1(.clk(clk), .reset(rst1), .bus(i1));
  typedef struct {
    logic [7:0] a, b;
    logic bin, ch;
    logic [7:0] d;
    logic bo, ov, z;
  } vec_t;
  int total = 0, bad = 0;
  vec_t q8[$], q1[$];
  vec_t tbl[10];
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) if (i8.done) begin
    vec_t e;
    if (q8.size() == 0) chk("spurious_done8", 1, 0);
    else begin
      e = q8.pop_front();
      chk("diff8", int'(i8.diff), int'(e.d));
      chk("borrow8", int'(i8.borrow_out), int'(e.bo));
      chk("overflow8", int'(i8.overflow), int'(e.ov));
      chk("zero8", int'(i8.zero), int'(e.z));
      chk("busy_at_done8", int'(i8.busy), 0);
    end
  end
  always @(negedge clk) if (i1.done) begin
    vec_t e;
    if (q1.size() == 0) chk("spurious_done1", 1, 0);
    else begin
      e = q1.pop_front();
      chk("diff1", int'(i1.diff), int'(e.d[0]));
      chk("borrow1", int'(i1.borrow_out), int'(e.bo));
      chk("overflow1", int'(i1.overflow), int'(e.ov));
      chk("zero1", int'(i1.zero), int'(e.z));
      chk("busy_at_done1", int'(i1.busy), 0);
    end
  end
  task automatic run8(input vec_t v, input int pulse_at = 0);
    bit seen = 0;
    @(posedge clk); #1;
    i8.a = v.a; i8.b = v.b; i8.borrow_in = v.bin; i8.chain = v.ch; i8.start = 1'b1;
    q8.push_back(v);
    @(posedge clk); #1;
    i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom); i8.borrow_in = 1'($urandom); i8.chain = 1'($urandom);
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (i8.done) begin
        seen = 1;
        chk("done_cycle8", n, 9);
      end else chk("busy8", int'(i8.busy), int'(n <= 8));
      i8.start = (n == pulse_at);
      if (n == pulse_at) begin i8.a = 8'h10; i8.b = 8'h01; i8.chain = 1'b0; end
    end
    if (!seen) chk("done_timeout8", 0, 1);
  endtask
  task automatic run1(input logic a, input logic b, input logic bin);
    vec_t v;
    int r, rs;
    bit seen = 0;
    r = int'(a) - int'(b) - int'(bin);
    rs = -int'(a) + int'(b) - int'(bin);
    v.a = {7'd0, a}; v.b = {7'd0, b}; v.bin = bin; v.ch = 1'b0;
    v.d = {7'd0, r[0]}; v.bo = r < 0; v.ov = rs < -1 || rs > 0; v.z = r[0] == 1'b0;
    @(posedge clk); #1;
    i1.a = a; i1.b = b; i1.borrow_in = bin; i1.chain = 1'b0; i1.start = 1'b1;
    q1.push_back(v);
    @(posedge clk); #1;
    i1.start = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (i1.done) begin
        seen = 1;
        chk("done_cycle1", n, 2);
      end else chk("busy1", int'(i1.busy), int'(n <= 1));
    end
    if (!seen) chk("done_timeout1", 0, 1);
  endtask
  initial begin
    tbl[0] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h42, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{8'h80, 8'h00, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    {i8.start, i8.chain, i8.borrow_in, i8.a, i8.b} = '0;
    {i1.start, i1.chain, i1.borrow_in, i1.a, i1.b} = '0;
    rst8 = 1'b1; rst1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_diff8", int'(i8.diff), 0);
    chk("rst_borrow8", int'(i8.borrow_out), 0);
    chk("rst_overflow8", int'(i8.overflow), 0);
    chk("rst_zero8", int'(i8.zero), 0);
    chk("rst_busy8", int'(i8.busy), 0);
    chk("rst_done8", int'(i8.done), 0);
    chk("rst_busy1", int'(i1.busy), 0);
    chk("rst_diff1", int'(i1.diff), 0);
    rst8 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 8; i++) run1(i[2], i[1], i[0]);
    for (int i = 0; i < 10; i++) run8(tbl[i]);
    run8(tbl[0], 4);
    run8(tbl[4]);
    @(posedge clk); #1;
    i8.a = 8'h12; i8.b = 8'h34; i8.borrow_in = 1'b0; i8.chain = 1'b0; i8.start = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", int'(i8.busy), 0);
    chk("abort_diff", int'(i8.diff), 0);
    chk("abort_done", int'(i8.done), 0);
    chk("abort_borrow", int'(i8.borrow_out), 0);
    rst8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    i8.a = 8'h05; i8.b = 8'h03; i8.start = 1'b1; rst8 = 1'b1;
    @(posedge clk); #1;
    i8.start = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    chk("reset_beats_start_busy", int'(i8.busy), 0);
    repeat (12) @(posedge clk);
    run8('{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
    run8(tbl[0]);
    repeat (5) @(posedge clk);
    chk("queue8_drained", q8.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_full_subtract.md
# serial_full_subtract

Bit-serial, parametrised successor to the single-bit full subtractor. It computes `a - b - borrow_in` over `WIDTH` bits by reusing one full-subtract cell, one bit per clock, LSB first, under a start/done handshake. It also reports borrow, signed overflow and zero, and can chain its borrow across successive operations for multi-word subtraction. It sits in the lab datapath wherever area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1..32.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a subtraction; sampled only in IDLE.
- `chain`  in  1: sampled with `start`.
  - 0: initial borrow comes from `borrow_in`.
  - 1: initial borrow comes from the stored `borrow_out` of the previous operation.
- `a`  in  WIDTH: minuend; captured when `start` is accepted.
- `b`  in  WIDTH: subtrahend; captured when `start` is accepted.
- `borrow_in`  in  1: initial borrow when `chain=0`; captured with `a`/`b`.
- `diff`  out  WIDTH: result, `(a - b - borrow) mod 2^WIDTH`.
- `borrow_out`  out  1: borrow out of the MSB.
- `overflow`  out  1: signed (two's-complement) overflow.
- `zero`  out  1: high when `diff == 0`.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: one-cycle pulse when the result is valid.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - On `start=1`: load `a` and `b` into shift registers.
  - Load the borrow register with `chain ? borrow_out : borrow_in`.
  - Clear the bit counter and capture `a[WIDTH-1]` and `b[WIDTH-1]`.
  - Go to SHIFT.
  - `start=0`: stay in IDLE; all outputs hold.
- **SHIFT**, per bit:
  - `d = a0 ^ b0 ^ br`.
  - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - Shift `d` into the result register from the MSB side.
  - Shift `a` and `b` right by 1.
  - Increment the counter.
  - After bit `WIDTH-1`, go to DONE.
- **DONE**
  - `done=1` for exactly one cycle.
  - Update `diff`, `borrow_out`, `overflow` and `zero` in the same edge that enters DONE; they hold until the next entry to DONE or reset.
  - `overflow = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb)`.
  - Always returns to IDLE next cycle.
- `start` while in SHIFT or DONE is ignored; there is no queueing.
- `chain` ignores `borrow_in`. Chain is intended for LS-word-first multi-word subtraction.
- `WIDTH=1` degenerates to the single-bit full subtractor with one SHIFT cycle.

## Timing
- Reset:
  - State goes to IDLE.
  - `diff=0`, `borrow_out=0`, `overflow=0`, `zero=0`, `busy=0`, `done=0`.
  - The stored chain borrow is cleared.
- Reset asserted mid-operation aborts it. No `done` is produced, and the partial result is never visible on `diff`.
- Cycle numbering: `start` is high in cycle 0.
  - `busy` is high in cycles 1..WIDTH.
  - `done` is high in cycle WIDTH+1, with `busy=0` in that cycle.
  - The earliest next accepted `start` is in cycle WIDTH+2.
- Latency: WIDTH+1 cycles from `start` to `done`. Throughput: one operation per WIDTH+2 cycles.
- `a`, `b`, `borrow_in` and `chain` are don't-care after the accepting edge.
- `reset` and `start` in the same cycle: reset wins and the start is dropped.

## Test plan
- Single bit (`WIDTH=1`): drive all 8 combinations of `a`/`b`/`borrow_in`, including 1-1-0, 0-1-0, 1-0-0 and 1-0-1. Required: results match the full-subtract truth table; for 1-0-1, `diff=0`, `borrow_out=0`; `done` arrives in cycle 2.
- Basic (`WIDTH=8`):
  - 0x05 - 0x03, bin=0 → `diff=0x02`, `borrow_out=0`, `zero=0`, `done` in cycle 9.
  - 0x03 - 0x05 → `diff=0xFE`, `borrow_out=1`.
- Overflow and zero (`WIDTH=8`):
  - 0x80 - 0x01 → `diff=0x7F`, `overflow=1`, `borrow_out=0`.
  - 0x42 - 0x42 → `diff=0x00`, `zero=1`.
- Chaining (`WIDTH=8`): compute 0x0100 - 0x0001 as two ops.
  - Low word 0x00 - 0x01, chain=0 → `diff=0xFF`, `borrow_out=1`.
  - High word 0x01 - 0x00, chain=1, with `borrow_in` held at 0 → `diff=0x00`, `borrow_out=0`.
- Handshake: pulse `start` again in cycle 4 of a busy operation → it is ignored. Only one `done` appears, in cycle 9, with the first operation's result.
- Reset mid-operation: assert `reset` in cycle 5 → next cycle `busy=0` and `diff=0`, no `done` pulse. A fresh `start` afterwards completes normally.
